req_capture_4: RTL and testbench
================================

# req_capture_4

Four-channel request capture stage that sits directly upstream of the 4-input priority encoder, driving its `x[4:1]` input. Asynchronous request lines are synchronised and rising-edge detected, then held as sticky pending bits until the consumer acknowledges them. The consumer acknowledges using the encoder's 3-bit `pcode` value. Lost events, meaning a new edge on a channel that is still pending, are recorded in sticky overflow flags.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops per channel; legal range 2..4.
- `clk`  input  1  — single clock; all state updates on its rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `req_in`  input  [4:1]  — raw asynchronous request lines; an event is a 0→1 transition.
- `enable`  input  [4:1]  — synchronous per-channel enable; an edge on a disabled channel is dropped.
- `ack`  input  1  — single-cycle acknowledge strobe.
- `ack_code`  input  [2:0]  — channel being acknowledged, in pcode encoding (1..4 = channel 1..4; 0 and 5..7 are invalid).
- `ovf_clr`  input  1  — clears all overflow flags.
- `x`  output  [4:1]  — registered pending vector; feeds the priority encoder `x` port.
- `irq`  output  1  — OR of `x`; combinational from the pending register, with no added latency.
- `overflow`  output  [4:1]  — sticky per-channel lost-event flags.

## Operation
- **Synchroniser.** Each channel `n` has a chain `s_n[1..SYNC_STAGES]`. `s_n[1]` samples `req_in[n]`.
- **Edge detect.** `prev_n` registers `s_n[SYNC_STAGES]`. The edge signal is `edge_n = s_n[SYNC_STAGES] & ~prev_n & enable[n]`.
- **Pending update, per channel, each edge.**
  - Set term: `edge_n`.
  - Clear term: `ack & (ack_code == n)`.
  - Next value: if set, 1; else if clear, 0; else hold.
  - Set and clear in the same cycle: set wins, so the new event is kept and the old one is considered consumed.
- **Overflow.**
  - `overflow[n]` is set when `edge_n` occurs while `pending[n]` is 1 and the same cycle does not clear channel `n`.
  - `ovf_clr` zeroes all flags.
  - A new overflow in the same cycle as `ovf_clr` wins; that flag stays 1.
- **Invalid or stale acknowledges.**
  - An `ack` with `ack_code` of 0 or 5..7 has no effect.
  - An `ack` naming a channel that is not pending has no effect.
- **Independence.** All four channels are independent and may set simultaneously. Only one channel can be cleared per cycle.
- **Enable timing.** `enable` is applied at the edge-detect point, not at the synchroniser. Deasserting it does not clear existing pending bits.
- **Held requests.** A request held high produces exactly one event. A new event requires `req_in` to return to 0 for long enough to propagate through the synchroniser.

## Timing
- **Reset values.**
  - All sync flops, `prev`, pending and `overflow` reset to 0.
  - Therefore `x` = 4'b0000, `irq` = 0 and `overflow` = 4'b0000 during reset.
  - Reset is asynchronous: outputs clear immediately on `rst` assertion, including mid-operation. Any in-flight synchroniser contents are discarded.
- **Request held high across reset.** Because `prev` resets to 0, it generates one event after release. With `SYNC_STAGES` = 2, `x[n]` rises after the 3rd rising edge following `rst` deassertion.
- **Set latency.** With `req_in[n]` rising before edge k, `x[n]` is 1 after edge k+SYNC_STAGES. This is 3 edges for the default.
- **Acknowledge latency.** With `ack` sampled at edge j, `x[n]` is 0 after edge j. `irq` follows in the same cycle.
- **Minimum pulse width.** `req_in` low and high times of at least SYNC_STAGES+1 clocks each are guaranteed to be seen. Shorter pulses may be missed.

## Test plan
- **Reset with request high.** Hold `rst`=1 with `req_in`=4'b1010 → `x`=0, `irq`=0. Release `rst` → `x`=4'b1010 after the 3rd edge, `irq`=1.
- **Single event and acknowledge.**
  - Pulse `req_in[3]` high for 4 clocks, `enable`=4'b1111 → `x`=4'b0100 three edges later.
  - `ack`=1, `ack_code`=3'd3 for one cycle → `x`=0 and `irq`=0 on the next edge.
- **Overflow and clear.**
  - Two separated pulses on `req_in[1]` without an ack → `x[1]`=1, `overflow`=4'b0001.
  - `ovf_clr` pulse → `overflow`=0, `x[1]` still 1.
- **Set/clear collision.** A new edge on channel 2 lands in the same cycle as `ack` with `ack_code`=3'd2 → `x[2]` stays 1 and `overflow[2]` stays 0.
- **Enable and invalid acknowledge.**
  - `enable`=4'b0111 with a pulse on `req_in[4]` → `x[4]` stays 0.
  - `ack` with `ack_code`=3'd0, then 3'd6, while `x`=4'b0011 → `x` unchanged.
- **Asynchronous reset mid-operation.** Assert `rst` between clock edges while `x`=4'b1111 and `overflow`=4'b0100 → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/req_capture_4.sv
// Four-channel request capture: synchronise, rising-edge detect, hold sticky
// pending bits until acknowledged by pcode, and flag events lost while pending.
module req_capture_4 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:1] req_in,
   input  logic [4:1] enable,
   input  logic       ack,
   input  logic [2:0] ack_code,
   input  logic       ovf_clr,
   output logic [4:1] x,
   output logic       irq,
   output logic [4:1] overflow
);

   logic [4:1] sync [1:SYNC_STAGES];
   logic [4:1] prev;
   logic [4:1] pending;
   logic [4:1] ovf;
   logic [4:1] edge_det;
   logic [4:1] clr;
   logic [4:1] pending_nxt;
   logic [4:1] ovf_nxt;

   always_comb begin
      // NOTE: every variable gets a default before any conditional logic, so
      // no path can leave one unassigned and infer a latch.
      clr = '0;
      for (int n = 1; n <= 4; n++) begin
         clr[n] = ack && (ack_code == 3'(n));
      end
      edge_det    = sync[SYNC_STAGES] & ~prev & enable;
      // A new edge beats a same-cycle clear: the old event is consumed, the new one kept.
      pending_nxt = edge_det | (pending & ~clr);
      // A fresh overflow beats ovf_clr; a same-cycle clear of the channel means nothing was lost.
      ovf_nxt     = (edge_det & pending & ~clr) | (ovf & {4{~ovf_clr}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the synchroniser array is reset too, so in-flight samples are
         // discarded and a request held through reset yields exactly one event.
         for (int i = 1; i <= SYNC_STAGES; i++) begin
            sync[i] <= '0;
         end
         prev    <= '0;
         pending <= '0;
         ovf     <= '0;
      end else begin
         // NOTE: non-blocking so each stage takes its neighbour's pre-edge
         // value; blocking here would collapse the chain into one flop.
         sync[1] <= req_in;
         for (int i = 2; i <= SYNC_STAGES; i++) begin
            sync[i] <= sync[i-1];
         end
         prev    <= sync[SYNC_STAGES];
         pending <= pending_nxt;
         ovf     <= ovf_nxt;
      end
   end

   assign x        = pending;
   assign irq      = |pending;
   assign overflow = ovf;

endmodule

// File: tb/tb_req_capture_4.sv
// Directed self-checking bench for req_capture_4 (default SYNC_STAGES = 2).
module tb_req_capture_4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:1] req_in;
   logic [4:1] enable;
   logic       ack;
   logic [2:0] ack_code;
   logic       ovf_clr;
   logic [4:1] x;
   logic       irq;
   logic [4:1] overflow;

   int checks = 0;
   int errors = 0;

   req_capture_4 #(.SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_in   (req_in),
      .enable   (enable),
      .ack      (ack),
      .ack_code (ack_code),
      .ovf_clr  (ovf_clr),
      .x        (x),
      .irq      (irq),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch);
      req_in[ch] = 1'b1;
      repeat (4) tick();
      req_in[ch] = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      rst      = 1'b1;
      req_in   = 4'b1010;
      enable   = 4'b1111;
      ack      = 1'b0;
      ack_code = 3'd0;
      ovf_clr  = 1'b0;

      // Reset with requests held high
      repeat (3) tick();
      check("reset_x", 32'(x), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_ovf", 32'(overflow), 32'h0);
      rst = 1'b0;
      tick();
      tick();
      check("rel_edge2_x", 32'(x), 32'h0);
      tick();
      check("rel_edge3_x", 32'(x), 32'b1010);
      check("rel_edge3_irq", 32'(irq), 32'h1);

      // Acknowledge both channels one at a time
      ack = 1'b1; ack_code = 3'd2;
      tick();
      check("ack2_x", 32'(x), 32'b1000);
      ack_code = 3'd4;
      tick();
      ack = 1'b0;
      check("ack4_x", 32'(x), 32'h0);
      check("ack4_irq", 32'(irq), 32'h0);
      req_in = 4'b0000;
      repeat (4) tick();
      check("held_no_reevent", 32'(x), 32'h0);

      // Single event on channel 3 and set latency
      req_in[3] = 1'b1;
      tick();
      tick();
      check("ch3_edge2_x", 32'(x), 32'h0);
      tick();
      check("ch3_edge3_x", 32'(x), 32'b0100);
      check("ch3_irq", 32'(irq), 32'h1);
      tick();
      req_in[3] = 1'b0;
      ack = 1'b1; ack_code = 3'd3;
      tick();
      ack = 1'b0;
      check("ch3_ack_x", 32'(x), 32'h0);
      check("ch3_ack_irq", 32'(irq), 32'h0);
      repeat (4) tick();

      // Overflow on channel 1 and clear
      pulse(1);
      check("ch1_first_x", 32'(x), 32'b0001);
      check("ch1_first_ovf", 32'(overflow), 32'h0);
      pulse(1);
      check("ch1_second_x", 32'(x), 32'b0001);
      check("ch1_second_ovf", 32'(overflow), 32'b0001);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr_ovf", 32'(overflow), 32'h0);
      check("ovf_clr_x", 32'(x), 32'b0001);

      // Set/clear collision on channel 2
      pulse(2);
      check("ch2_pending", 32'(x), 32'b0011);
      req_in[2] = 1'b1;
      tick();
      tick();
      ack = 1'b1; ack_code = 3'd2;
      tick();
      ack = 1'b0;
      check("collide_x", 32'(x), 32'b0011);
      check("collide_ovf", 32'(overflow), 32'h0);
      req_in[2] = 1'b0;
      repeat (4) tick();

      // Disabled channel 4 drops its edge
      enable = 4'b0111;
      pulse(4);
      check("disabled_ch4_x", 32'(x), 32'b0011);
      enable = 4'b1111;

      // Invalid and stale acknowledges
      ack = 1'b1; ack_code = 3'd0;
      tick();
      check("ack_code0_x", 32'(x), 32'b0011);
      ack_code = 3'd6;
      tick();
      check("ack_code6_x", 32'(x), 32'b0011);
      ack_code = 3'd3;
      tick();
      ack = 1'b0;
      check("ack_stale3_x", 32'(x), 32'b0011);
      check("ack_invalid_ovf", 32'(overflow), 32'h0);

      // Build x = 1111, overflow = 0100
      pulse(3);
      pulse(3);
      pulse(4);
      check("pre_rst_x", 32'(x), 32'b1111);
      check("pre_rst_ovf", 32'(overflow), 32'b0100);

      // Asynchronous reset between edges
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_x", 32'(x), 32'h0);
      check("async_rst_irq", 32'(irq), 32'h0);
      check("async_rst_ovf", 32'(overflow), 32'h0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check("post_rst_x", 32'(x), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
